// File: rtl/fpu_mem_sequencer_if.sv
// rtl/fpu_mem_sequencer_if.sv - row-oriented memory transaction port
// Ports (master = sequencer, slave = memory):
//   mem_req        master->slave  transaction valid, held until mem_ack
//   mem_wr         master->slave  1 = drain buffer to memory, 0 = fill buffer
//   mem_addr       master->slave  byte address of the current row
//   mem_len        master->slave  bytes in the current row
//   mem_row        master->slave  buffer row index
//   mem_buffer_sel master->slave  buffer targeted by the transfer
//   mem_ack        slave->master  current row transaction completed
interface fpu_mem_sequencer_if #(
    parameter int COL_WIDTH = 10
);
    localparam int ROW_W = $clog2(COL_WIDTH);

    logic             mem_req;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [16:0]      mem_len;
    logic [ROW_W-1:0] mem_row;
    logic             mem_buffer_sel;
    logic             mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_len, mem_row, mem_buffer_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_len, mem_row, mem_buffer_sel,
        output mem_ack
    );
endinterface

// File: rtl/fpu_mem_sequencer.sv
// rtl/fpu_mem_sequencer.sv - sequences FPU buffer drain/refill rows onto one memory port
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   request_read/_write   level requests from the FPU controller
//   rd_buffer_sel         active read buffer; the idle one (inverse) is targeted
//   read_address          first input row byte address
//   write_address         first result row byte address
//   write_request_width   bytes per drained row
//   write_request_height  rows to drain (clamped to COL_WIDTH)
//   image_width           pixels per image row, source of both row strides
//   making_request        busy, stalls the controller
//   xfer_done             one-cycle pulse when the whole request is finished
//   mem                   row transaction port (master side)
module fpu_mem_sequencer #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       request_read,
    input  logic                       request_write,
    input  logic                       rd_buffer_sel,
    input  logic [31:0]                read_address,
    input  logic [31:0]                write_address,
    input  logic [16:0]                write_request_width,
    input  logic [8:0]                 write_request_height,
    input  logic [15:0]                image_width,
    output logic                       making_request,
    output logic                       xfer_done,
    fpu_mem_sequencer_if.master        mem
);
    localparam int ROW_W = $clog2(COL_WIDTH);
    localparam int HGT_W = $clog2(COL_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [HGT_W-1:0] height_q, height_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      rd_base_q, rd_base_d;
    logic [31:0]      rd_stride_q, rd_stride_d;
    logic [31:0]      wr_stride_q, wr_stride_d;
    logic [16:0]      wr_len_q, wr_len_d;
    logic [16:0]      len_q, len_d;
    logic             rd_flag_q, rd_flag_d;
    logic             sel_q, sel_d;
    logic             req_q, req_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             write_go;
    logic             last_wr_row;
    logic             last_rd_row;

    // A drain with zero width or zero height moves no data and is skipped.
    assign write_go    = request_write && (write_request_width != '0) && (write_request_height != '0);
    assign last_wr_row = (HGT_W'(row_q) + HGT_W'(1)) == height_q;
    assign last_rd_row = row_q == ROW_W'(COL_WIDTH - 1);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        height_d    = height_q;
        addr_d      = addr_q;
        rd_base_d   = rd_base_q;
        rd_stride_d = rd_stride_q;
        wr_stride_d = wr_stride_q;
        wr_len_d    = wr_len_q;
        rd_flag_d   = rd_flag_q;
        sel_d       = sel_q;

        case (state_q)
            IDLE: begin
                if (request_read || request_write) begin
                    rd_base_d   = read_address;
                    rd_flag_d   = request_read;
                    sel_d       = !rd_buffer_sel;
                    wr_len_d    = write_request_width;
                    height_d    = (write_request_height > 9'(COL_WIDTH)) ?
                                  HGT_W'(COL_WIDTH) : HGT_W'(write_request_height);
                    rd_stride_d = (32'(image_width) + 32'd2) * 32'd3;
                    wr_stride_d = 32'(image_width) * 32'd3 + 32'd4;
                    row_d       = '0;
                    if (write_go) begin
                        state_d = WRITE;
                        addr_d  = write_address;
                    end else if (request_read) begin
                        state_d = READ;
                        addr_d  = read_address;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (mem.mem_ack) begin
                    if (last_wr_row) begin
                        row_d = '0;
                        if (rd_flag_q) begin
                            state_d = READ;
                            addr_d  = rd_base_q;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        row_d  = row_q + ROW_W'(1);
                        addr_d = addr_q + wr_stride_q;
                    end
                end
            end
            READ: begin
                if (mem.mem_ack) begin
                    if (last_rd_row) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d  = row_q + ROW_W'(1);
                        addr_d = addr_q + rd_stride_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop in step with it.
    always_comb begin
        req_d  = (state_d == WRITE) || (state_d == READ);
        wr_d   = state_d == WRITE;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        len_d  = '0;
        if (state_d == WRITE) begin
            len_d = wr_len_d;
        end else if (state_d == READ) begin
            len_d = 17'(MEM_BUFFER_WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            height_q    <= '0;
            addr_q      <= '0;
            rd_base_q   <= '0;
            rd_stride_q <= '0;
            wr_stride_q <= '0;
            wr_len_q    <= '0;
            len_q       <= '0;
            rd_flag_q   <= 1'b0;
            sel_q       <= 1'b0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            height_q    <= height_d;
            addr_q      <= addr_d;
            rd_base_q   <= rd_base_d;
            rd_stride_q <= rd_stride_d;
            wr_stride_q <= wr_stride_d;
            wr_len_q    <= wr_len_d;
            len_q       <= len_d;
            rd_flag_q   <= rd_flag_d;
            sel_q       <= sel_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem.mem_req        = req_q;
    assign mem.mem_wr         = wr_q;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_len        = len_q;
    assign mem.mem_row        = row_q;
    assign mem.mem_buffer_sel = sel_q;
    assign making_request     = busy_q;
    assign xfer_done          = done_q;
endmodule

// File: tb/tb_fpu_mem_sequencer.sv
// tb/tb_fpu_mem_sequencer.sv - randomized self-checking bench for fpu_mem_sequencer
module tb_fpu_mem_sequencer;
    localparam int COL_WIDTH = 10;
    localparam int MBW       = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        request_read, request_write, rd_buffer_sel;
    logic [31:0] read_address, write_address;
    logic [16:0] write_request_width;
    logic [8:0]  write_request_height;
    logic [15:0] image_width;
    logic        making_request, xfer_done;

    always #5 clk = ~clk;

    fpu_mem_sequencer_if #(.COL_WIDTH(COL_WIDTH)) mem_if ();

    fpu_mem_sequencer #(.COL_WIDTH(COL_WIDTH), .MEM_BUFFER_WIDTH(MBW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .request_read         (request_read),
        .request_write        (request_write),
        .rd_buffer_sel        (rd_buffer_sel),
        .read_address         (read_address),
        .write_address        (write_address),
        .write_request_width  (write_request_width),
        .write_request_height (write_request_height),
        .image_width          (image_width),
        .making_request       (making_request),
        .xfer_done            (xfer_done),
        .mem                  (mem_if)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on accept, the full list of row transactions is
    // expanded with plain arithmetic; each ack while a row is pending pops one.
    typedef struct {
        bit          wr;
        int unsigned addr;
        int unsigned len;
        int unsigned row;
        bit          sel;
    } tx_t;

    tx_t         txq[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_h;

    always @(posedge clk) begin
        if (rst) begin
            txq.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (request_read || request_write) begin
                m_h = (write_request_height > COL_WIDTH) ? COL_WIDTH : write_request_height;
                if (request_write && write_request_width != 0 && m_h != 0)
                    for (int k = 0; k < int'(m_h); k++)
                        txq.push_back('{1'b1, write_address + k * (image_width * 3 + 4),
                                        write_request_width, k, !rd_buffer_sel});
                if (request_read)
                    for (int k = 0; k < COL_WIDTH; k++)
                        txq.push_back('{1'b0, read_address + k * ((image_width + 2) * 3),
                                        MBW, k, !rd_buffer_sel});
                m_busy = 1'b1;
                m_done = (txq.size() == 0);
            end
        end else if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (mem_if.mem_ack && txq.size() > 0) begin
            void'(txq.pop_front());
            if (txq.size() == 0) m_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_if.mem_req, (m_busy && txq.size() > 0));
            chk("making_request", making_request, m_busy);
            chk("xfer_done", xfer_done, m_done);
            if (m_busy && txq.size() > 0) begin
                chk("mem_wr", mem_if.mem_wr, txq[0].wr);
                chk("mem_addr", mem_if.mem_addr, txq[0].addr);
                chk("mem_len", mem_if.mem_len, txq[0].len);
                chk("mem_row", mem_if.mem_row, txq[0].row);
                chk("mem_buffer_sel", mem_if.mem_buffer_sel, txq[0].sel);
            end
        end
    end

    // Ack generator: 0 = never, 1 = every cycle, 2 = random 0-5 cycle delay, 3 = noise.
    int ack_mode = 0;
    int ack_wait = 0;
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: mem_if.mem_ack = 1'b0;
            1: mem_if.mem_ack = 1'b1;
            2: begin
                if (mem_if.mem_req && ack_wait == 0) begin
                    mem_if.mem_ack = 1'b1;
                    ack_wait = $urandom_range(0, 5);
                end else begin
                    mem_if.mem_ack = 1'b0;
                    if (mem_if.mem_req) ack_wait--;
                end
            end
            default: mem_if.mem_ack = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request; returns just after the accept edge with requests dropped
    // and the remaining inputs scrambled (they must no longer matter).
    task automatic start_req(input bit rr, input bit rw, input logic [31:0] ra, input logic [31:0] wa,
                             input logic [16:0] w, input logic [8:0] h, input logic [15:0] iw,
                             input bit sel, output bit done_now);
        request_read         = rr;
        request_write        = rw;
        read_address         = ra;
        write_address        = wa;
        write_request_width  = w;
        write_request_height = h;
        image_width          = iw;
        rd_buffer_sel        = sel;
        tick();
        done_now             = xfer_done;
        request_read         = 1'b0;
        request_write        = 1'b0;
        read_address         = $urandom;
        write_address        = $urandom;
        write_request_width  = 17'($urandom);
        write_request_height = 9'($urandom);
        image_width          = 16'($urandom);
        rd_buffer_sel        = 1'($urandom);
    endtask

    // Returns total cycles from the request cycle through the xfer_done cycle.
    task automatic finish_req(input bit done_now, output int total);
        bit found;
        found = done_now;
        total = 2;
        for (int k = 2; k < 400 && !found; k++) begin
            tick();
            if (xfer_done) begin
                found = 1'b1;
                total = k + 1;
            end
        end
        chk("done_within_bound", found, 1'b1);
        tick();
    endtask

    bit dn;
    int tot;
    bit hit;

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        request_read = 1'b0; request_write = 1'b0; rd_buffer_sel = 1'b0;
        read_address = '0; write_address = '0; write_request_width = '0;
        write_request_height = '0; image_width = '0;
        mem_if.mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", mem_if.mem_req, 0);
        chk("rst_mem_wr", mem_if.mem_wr, 0);
        chk("rst_mem_addr", mem_if.mem_addr, 0);
        chk("rst_mem_len", mem_if.mem_len, 0);
        chk("rst_mem_row", mem_if.mem_row, 0);
        chk("rst_mem_buffer_sel", mem_if.mem_buffer_sel, 0);
        chk("rst_making_request", making_request, 0);
        chk("rst_xfer_done", xfer_done, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        ack_mode = 3;
        repeat (5) tick();
        ack_mode = 0;
        tick();
        chk("idle_making_request", making_request, 0);

        // Read only, ack every cycle.
        ack_mode = 1;
        start_req(1, 0, 32'd0, 32'd0, 17'd0, 9'd0, 16'd210, 0, dn);
        chk("rd_q_size", txq.size(), 10);
        chk("rd_q_addr1", txq[1].addr, 636);
        chk("rd_q_addr9", txq[9].addr, 5724);
        chk("rd_first_addr", mem_if.mem_addr, 0);
        chk("rd_first_len", mem_if.mem_len, 512);
        chk("rd_buffer_sel", mem_if.mem_buffer_sel, 1);
        finish_req(dn, tot);
        chk("rd_total_cycles", tot, 12);

        // Write + read with random ack delays.
        ack_mode = 2;
        start_req(1, 1, 32'd192, 32'd5168, 17'd192, 9'd8, 16'd210, 1, dn);
        chk("wr_q_size", txq.size(), 18);
        chk("wr_q_addr7", txq[7].addr, 9606);
        chk("wr_q_addr8", txq[8].addr, 192);
        chk("wr_q_last", txq[17].addr, 5916);
        chk("wr_first_mem_wr", mem_if.mem_wr, 1);
        chk("wr_first_len", mem_if.mem_len, 192);
        finish_req(dn, tot);

        // Same request at full ack rate: minimum total latency.
        ack_mode = 1;
        start_req(1, 1, 32'd192, 32'd5168, 17'd192, 9'd8, 16'd210, 0, dn);
        finish_req(dn, tot);
        chk("wr_rd_total_cycles", tot, 20);

        // Zero-width write skipped, read only.
        start_req(1, 1, 32'd64, 32'd4096, 17'd0, 9'd8, 16'd100, 0, dn);
        chk("deg_q_size", txq.size(), 10);
        chk("deg_mem_wr", mem_if.mem_wr, 0);
        finish_req(dn, tot);

        // Write-only with height 0: done on the cycle after accept.
        start_req(0, 1, 32'd0, 32'd4096, 17'd64, 9'd0, 16'd100, 0, dn);
        chk("h0_done_now", dn, 1);
        chk("h0_mem_req", mem_if.mem_req, 0);
        finish_req(dn, tot);

        // Height clamp.
        start_req(0, 1, 32'd0, 32'd1000, 17'd5, 9'd300, 16'd7, 1, dn);
        chk("clamp_q_size", txq.size(), 10);
        finish_req(dn, tot);

        // Reset during WRITE row 3.
        ack_mode = 2;
        start_req(1, 1, 32'd192, 32'd5168, 17'd192, 9'd8, 16'd210, 0, dn);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (mem_if.mem_req && mem_if.mem_wr && mem_if.mem_row == 3) hit = 1'b1;
            else tick();
        end
        chk("reached_write_row3", hit, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_mem_req", mem_if.mem_req, 0);
        chk("abort_making_request", making_request, 0);
        rst = 1'b0;
        tick();
        ack_mode = 1;
        start_req(0, 1, 32'd0, 32'd800, 17'd32, 9'd4, 16'd50, 0, dn);
        chk("restart_row", mem_if.mem_row, 0);
        chk("restart_addr", mem_if.mem_addr, 800);
        finish_req(dn, tot);

        // Requests held high across DONE.
        request_read = 1'b1; image_width = 16'd40; read_address = 32'd10000; rd_buffer_sel = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            tick();
            if (xfer_done) hit = 1'b1;
        end
        chk("hold_first_done", hit, 1'b1);
        tick();
        chk("hold_gap_low", making_request, 0);
        tick();
        chk("hold_restart_high", making_request, 1);
        chk("hold_restart_row", mem_if.mem_row, 0);
        request_read = 1'b0;
        finish_req(1'b0, tot);
        repeat (3) tick();
        chk("hold_no_third", making_request, 0);

        // Randomized requests.
        for (int i = 0; i < 30; i++) begin
            bit rr, rw;
            ack_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            rr = 1'($urandom_range(0, 1));
            rw = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            start_req(rr, rw, $urandom, $urandom,
                      ($urandom_range(0, 4) == 0) ? 17'd0 : 17'($urandom),
                      9'($urandom_range(0, 14)), 16'($urandom), 1'($urandom), dn);
            finish_req(dn, tot);
        end

        ack_mode = 0;
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
